// File: rtl/manch_de_if.sv
// manch_de_if: serial line plus host-side word/handshake signals of the
// Manchester decoder. The host/line side takes the master view; the decoder
// takes the slave view.
interface manch_de_if #(
    parameter int unsigned DW = 8
);
    logic          mdi;
    logic          rdn;
    logic [DW-1:0] dout;
    logic          data_ready;
    logic          code_err;
    logic          overrun;

    modport master (
        output mdi, rdn,
        input  dout, data_ready, code_err, overrun
    );

    modport slave (
        input  mdi, rdn,
        output dout, data_ready, code_err, overrun
    );
endinterface

// File: rtl/manch_de.sv
// manch_de: Manchester decoder. Oversamples mdi at BIT_CYC clocks per bit,
// qualifies the start bit, recovers DW data bits MSB first and checks every
// mid-bit transition. The decoded word is offered with a ready/read handshake.
// Optional build macro MANCH_DE_RESYNC_EN: re-centre the cell counter on each
// mid-bit transition so that per-bit clock drift is tracked.
module manch_de #(
    parameter int unsigned DW      = 8,
    parameter int unsigned BIT_CYC = 16
) (
    input  logic      clk16x,
    input  logic      rstn,
    manch_de_if.slave bus
);
    localparam int unsigned CW = $clog2(BIT_CYC);
    localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [CW-1:0] Q1      = CW'(BIT_CYC / 4);
    localparam logic [CW-1:0] Q3      = CW'(3 * BIT_CYC / 4);
    localparam logic [CW-1:0] LAST    = CW'(BIT_CYC - 1);
    localparam logic [BW-1:0] LASTBIT = BW'(DW - 1);
`ifdef MANCH_DE_RESYNC_EN
    localparam logic [CW-1:0] WIN_LO  = CW'(BIT_CYC / 2 - 2);
    localparam logic [CW-1:0] WIN_HI  = CW'(BIT_CYC / 2 + 2);
    localparam logic [CW-1:0] RESYNC  = CW'(BIT_CYC / 2 + 1);
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_e;

    logic          sync1_q;
    logic          mdi_s_q;
    logic          mdi_p_q;
    logic          mdi_edge;
    logic          armed_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [BW-1:0] bitcnt_q;
    logic [DW-1:0] shift_q;
    logic [DW-1:0] dout_q;
    logic          data_ready_q;
    logic          code_err_q;
    logic          overrun_q;

    assign mdi_edge = mdi_s_q ^ mdi_p_q;

    // Two-flop synchronizer for mdi, plus one delayed copy for edge detection.
    always_ff @(posedge clk16x) begin
        if (rstn) begin
            sync1_q <= 1'b0;
            mdi_s_q <= 1'b0;
            mdi_p_q <= 1'b0;
        end else begin
            sync1_q <= bus.mdi;
            mdi_s_q <= sync1_q;
            mdi_p_q <= mdi_s_q;
        end
    end

    // Next cell-counter value while a frame is in progress.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
`ifdef MANCH_DE_RESYNC_EN
        // A transition near mid-cell is taken as the mid-bit edge and pins
        // the count to the value that follows a perfectly aligned edge.
        if (mdi_edge && (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI)) begin
            cnt_d = RESYNC;
        end
`endif
    end

    // Frame FSM, bit sampling and host handshake.
    always_ff @(posedge clk16x) begin
        if (rstn) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            data_ready_q <= 1'b0;
            code_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q    <= '0;
                    bitcnt_q <= '0;
                    if (!mdi_s_q) begin
                        armed_q <= 1'b1;
                    end
                    // The cycle that first sees mdi_s high counts as cnt 0.
                    if (armed_q && mdi_edge && mdi_s_q) begin
                        state_q <= START;
                        armed_q <= 1'b0;
                        cnt_q   <= CW'(1);
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (((cnt_q == Q1) && !mdi_s_q) || ((cnt_q == Q3) && mdi_s_q)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        state_q    <= DATA;
                        code_err_q <= 1'b0;
                        bitcnt_q   <= '0;
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == Q1) begin
                        shift_q <= {shift_q[DW-2:0], mdi_s_q};
                    end
                    if (cnt_q == Q3) begin
                        if (mdi_s_q == shift_q[0]) begin
                            code_err_q <= 1'b1;
                        end
                        if (bitcnt_q == LASTBIT) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                        end
                    end
                    if (cnt_q == LAST) begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                    end
                end
                DONE: begin
                    dout_q  <= shift_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // A completing frame takes precedence over a read in the same cycle.
            if (state_q == DONE) begin
                data_ready_q <= 1'b1;
                overrun_q    <= overrun_q | (data_ready_q & ~bus.rdn);
            end else if (bus.rdn && data_ready_q) begin
                data_ready_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.data_ready = data_ready_q;
    assign bus.code_err   = code_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_manch_de.sv
// tb_manch_de: drives Manchester frames into manch_de and compares the host
// side against a word-level model (last word, ready, code error, overrun).
module tb_manch_de;
    localparam int unsigned DW      = 8;
    localparam int unsigned BC      = 16;
    localparam int unsigned HW      = 2 * (DW + 1);
    // Posedges from the first edge that samples the pin high to data_ready
    // rising: 141 decoder cycles plus 2 synchronizer cycles.
    localparam int          NOM_LAT = 143;

    logic clk16x = 1'b0;
    logic rstn   = 1'b1;

    manch_de_if #(.DW(DW)) bus ();

    manch_de #(.DW(DW), .BIT_CYC(BC)) dut (
        .clk16x(clk16x),
        .rstn  (rstn),
        .bus   (bus)
    );

    always #5 clk16x = ~clk16x;

    int checks   = 0;
    int errors   = 0;
    int lat_seen = -1;

    logic [DW-1:0] m_dout;
    logic          m_ready;
    logic          m_err;
    logic          m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_dout"},  32'(bus.dout),       32'(m_dout));
        check({tag, "_ready"}, 32'(bus.data_ready), 32'(m_ready));
        check({tag, "_err"},   32'(bus.code_err),   32'(m_err));
        check({tag, "_ovr"},   32'(bus.overrun),    32'(m_ovr));
    endtask

    task automatic model_reset();
        m_dout  = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk16x);
        rstn = 1'b1;
        @(negedge clk16x);
        rstn = 1'b0;
        model_reset();
    endtask

    // Half-cell levels, first transmitted in the MSBs: start bit, then data.
    function automatic logic [HW-1:0] encode(input logic [DW-1:0] w, input logic [DW-1:0] bad);
        logic [HW-1:0] h;
        logic          f;
        h = HW'(2'b10);
        for (int b = DW - 1; b >= 0; b--) begin
            f = w[b];
            h = {h[HW-3:0], f, bad[b] ? f : ~f};
        end
        return h;
    endfunction

    task automatic send_frame(input logic [HW-1:0] h, input int cyc, input int ncells,
                              input bit measure, input bit rdn_at_done);
        lat_seen = -1;
        fork
            begin
                for (int c = 0; c < ncells; c++) begin
                    for (int k = 0; k < cyc; k++) begin
                        @(negedge clk16x);
                        bus.mdi = (k < cyc / 2) ? h[HW-1-2*c] : h[HW-2-2*c];
                    end
                end
                @(negedge clk16x);
                bus.mdi = 1'b0;
            end
            begin
                if (measure) begin
                    for (int k = 1; (k <= 300) && (lat_seen < 0); k++) begin
                        @(negedge clk16x);
                        if (bus.data_ready === 1'b1) lat_seen = k - 2;
                    end
                end
            end
            begin
                if (rdn_at_done) begin
                    repeat (144) @(negedge clk16x);
                    bus.rdn = 1'b1;
                    @(negedge clk16x);
                    bus.rdn = 1'b0;
                end
            end
        join
    endtask

    task automatic nominal(input string tag, input logic [DW-1:0] w, input logic [DW-1:0] bad,
                           input bit rdn_at_done);
        bit measure;
        measure = !m_ready;
        send_frame(encode(w, bad), BC, DW + 1, measure, rdn_at_done);
        repeat (4) @(negedge clk16x);
        if (measure) check({tag, "_lat"}, 32'(lat_seen), 32'(NOM_LAT));
        if (!rdn_at_done) m_ovr = m_ovr | m_ready;
        m_ready = 1'b1;
        m_dout  = w;
        m_err   = |bad;
        check_model(tag);
    endtask

    task automatic host_read(input string tag);
        @(negedge clk16x);
        bus.rdn = 1'b1;
        @(negedge clk16x);
        bus.rdn = 1'b0;
        if (m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
        @(negedge clk16x);
        check_model(tag);
    endtask

    task automatic drift(input string tag, input int cyc);
        send_frame(encode(8'h96, '0), cyc, DW + 1, 1'b1, 1'b0);
        repeat (2) @(negedge clk16x);
        check({tag, "_ready"}, 32'(bus.data_ready), 32'd1);
`ifdef MANCH_DE_RESYNC_EN
        check({tag, "_dout"}, 32'(bus.dout), 32'h96);
        check({tag, "_err"},  32'(bus.code_err), 32'd0);
`else
        check({tag, "_detected"}, 32'((bus.code_err === 1'b1) || (bus.dout !== 8'h96)), 32'd1);
`endif
        repeat (300) @(negedge clk16x);
        pulse_reset();
        repeat (5) @(negedge clk16x);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] lb [5];
        logic [DW-1:0] w;
        logic [DW-1:0] bad;

        lb = '{8'hFF, 8'hAA, 8'h00, 8'hF0, 8'h0F};
        bus.mdi = 1'b0;
        bus.rdn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk16x);
        rstn = 1'b0;
        repeat (2) @(negedge clk16x);
        check_model("reset");

        foreach (lb[i]) begin
            nominal("loop", lb[i], '0, 1'b0);
            host_read("loop_rd");
            repeat (5) @(negedge clk16x);
        end

        nominal("first", 8'hA5, '0, 1'b0);
        repeat (6) @(negedge clk16x);
        nominal("overrun", 8'h3C, '0, 1'b0);
        host_read("overrun_rd");

        nominal("codeerr", 8'h5A, 8'h08, 1'b0);
        host_read("codeerr_rd");
        nominal("errclr", 8'h11, '0, 1'b0);
        repeat (6) @(negedge clk16x);
        nominal("rd_at_done", 8'h66, '0, 1'b1);
        host_read("rd_at_done_rd");

        nominal("glitch_pre", 8'h5A, 8'h08, 1'b0);
        repeat (3) begin
            @(negedge clk16x);
            bus.mdi = 1'b1;
        end
        @(negedge clk16x);
        bus.mdi = 1'b0;
        repeat (40) @(negedge clk16x);
        check_model("glitch");

        send_frame(encode(8'h77, '0), BC, 5, 1'b0, 1'b0);
        pulse_reset();
        repeat (3) @(negedge clk16x);
        check_model("midrst");
        repeat (20) @(negedge clk16x);
        nominal("post_rst", 8'hC3, '0, 1'b0);
        host_read("post_rst_rd");

        for (int i = 0; i < 12; i++) begin
            w   = DW'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? (DW'(1) << $urandom_range(0, DW - 1)) : '0;
            nominal("rand", w, bad, 1'b0);
            if ($urandom_range(0, 1) == 1) host_read("rand_rd");
            repeat ($urandom_range(2, 30)) @(negedge clk16x);
        end

        pulse_reset();
        repeat (5) @(negedge clk16x);
        drift("drift17", 17);
        drift("drift15", 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
